// File: rtl/l1_cache_pkg.sv
// Shared types for the core-to-L1 request path: command encoding and the
// request master's state encoding.
package l1_cache_pkg;

  localparam int CORE_CMND_WIDTH = 2;

  typedef enum logic [CORE_CMND_WIDTH-1:0] {
    CMD_RD    = 2'b00,
    CMD_WR    = 2'b01,
    CMD_FLUSH = 2'b10,
    CMD_RSVD  = 2'b11
  } core_cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } l1_master_state_e;

  function automatic logic cmd_is_legal(input logic [CORE_CMND_WIDTH-1:0] cmd);
    return (cmd != CMD_RSVD);
  endfunction

endpackage

// File: rtl/l1_req_timeout_cnt.sv
// Outstanding-transaction watchdog: counts cycles while run is high and
// flags expiry on the final count. Used only when L1_REQ_TIMEOUT_EN is set.
module l1_req_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_r;

  // Saturate at LAST so a stalled abort cannot wrap back to zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_r <= '0;
    end else if (run && (count_r != LAST)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = run && (count_r == LAST);

endmodule

// File: rtl/l1_core_req_master.sv
// Core-side initiator of the core-to-L1 request interface, one transaction in
// flight. Optional watchdog abort is enabled by defining L1_REQ_TIMEOUT_EN.
module l1_core_req_master
  import l1_cache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [CORE_CMND_WIDTH-1:0] lsu_cmd,
  input  logic [ADDR_WIDTH-1:0]      lsu_addr,
  input  logic [DATA_WIDTH-1:0]      lsu_wdata,
  output logic                       lsu_rvalid,
  output logic [DATA_WIDTH-1:0]      lsu_rdata,
  output logic                       lsu_err,
  output logic                       req,
  output logic [CORE_CMND_WIDTH-1:0] cmd,
  output logic [ADDR_WIDTH-1:0]      addr,
  output logic [DATA_WIDTH-1:0]      wdata,
  input  logic                       req_ack,
  input  logic                       resp,
  input  logic [DATA_WIDTH-1:0]      rdata,
  output logic                       proto_err
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  l1_master_state_e           state_r, state_nx;
  logic                       req_r, req_nx;
  logic [CORE_CMND_WIDTH-1:0] cmd_r, cmd_nx;
  logic [ADDR_WIDTH-1:0]      addr_r, addr_nx;
  logic [DATA_WIDTH-1:0]      wdata_r, wdata_nx;
  logic                       rvalid_r, rvalid_nx;
  logic [DATA_WIDTH-1:0]      lrdata_r, lrdata_nx;
  logic                       err_r, err_nx;
  logic                       proto_r, proto_nx;
  logic                       ready_r;
  // orphan_r remembers that a reset abandoned an in-flight transaction, so the
  // L1's late response is swallowed instead of being reported as spurious.
  logic                       orphan_r, orphan_nx;
  logic                       timeout_s;

`ifdef L1_REQ_TIMEOUT_EN
  logic enter_req_s;
  logic run_s;

  assign enter_req_s = (state_r == IDLE) && (state_nx == REQ);
  assign run_s       = (state_r == REQ) || (state_r == WAIT);

  l1_req_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (enter_req_s),
    .run    (run_s),
    .expired(timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and next-output decode.
  always_comb begin
    state_nx  = state_r;
    req_nx    = 1'b0;
    cmd_nx    = cmd_r;
    addr_nx   = addr_r;
    wdata_nx  = wdata_r;
    rvalid_nx = 1'b0;
    lrdata_nx = '0;
    err_nx    = 1'b0;
    proto_nx  = proto_r;
    orphan_nx = orphan_r;
    case (state_r)
      IDLE: begin
        if (resp) begin
          if (orphan_r) begin
            orphan_nx = 1'b0;
          end else begin
            proto_nx = 1'b1;
          end
        end else begin
          orphan_nx = orphan_r;
        end
        if (lsu_valid) begin
          if (cmd_is_legal(lsu_cmd)) begin
            state_nx  = REQ;
            req_nx    = 1'b1;
            cmd_nx    = lsu_cmd;
            addr_nx   = lsu_addr;
            wdata_nx  = lsu_wdata;
            orphan_nx = 1'b0;
          end else begin
            rvalid_nx = 1'b1;
            err_nx    = 1'b1;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      REQ: begin
        req_nx = 1'b1;
        if (req_ack && resp) begin
          state_nx  = IDLE;
          req_nx    = 1'b0;
          rvalid_nx = 1'b1;
          lrdata_nx = (cmd_r == CMD_RD) ? rdata : '0;
        end else if (timeout_s) begin
          state_nx  = IDLE;
          req_nx    = 1'b0;
          rvalid_nx = 1'b1;
          err_nx    = 1'b1;
        end else if (req_ack) begin
          state_nx = WAIT;
          req_nx   = 1'b0;
        end else begin
          state_nx = REQ;
        end
      end
      WAIT: begin
        if (resp) begin
          state_nx  = IDLE;
          rvalid_nx = 1'b1;
          lrdata_nx = (cmd_r == CMD_RD) ? rdata : '0;
        end else if (timeout_s) begin
          state_nx  = IDLE;
          rvalid_nx = 1'b1;
          err_nx    = 1'b1;
        end else begin
          state_nx = WAIT;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      req_r    <= 1'b0;
      cmd_r    <= '0;
      addr_r   <= '0;
      wdata_r  <= '0;
      rvalid_r <= 1'b0;
      lrdata_r <= '0;
      err_r    <= 1'b0;
      proto_r  <= 1'b0;
      ready_r  <= 1'b1;
      orphan_r <= orphan_r | (state_r != IDLE);
    end else begin
      state_r  <= state_nx;
      req_r    <= req_nx;
      cmd_r    <= cmd_nx;
      addr_r   <= addr_nx;
      wdata_r  <= wdata_nx;
      rvalid_r <= rvalid_nx;
      lrdata_r <= lrdata_nx;
      err_r    <= err_nx;
      proto_r  <= proto_nx;
      ready_r  <= (state_nx == IDLE);
      orphan_r <= orphan_nx;
    end
  end

  assign lsu_ready  = ready_r;
  assign lsu_rvalid = rvalid_r;
  assign lsu_rdata  = lrdata_r;
  assign lsu_err    = err_r;
  assign req        = req_r;
  assign cmd        = cmd_r;
  assign addr       = addr_r;
  assign wdata      = wdata_r;
  assign proto_err  = proto_r;

endmodule

// File: tb/tb_l1_core_req_master.sv
// Self-checking bench for l1_core_req_master: vector table plus hand-written
// corner sequences, completions checked through a scoreboard queue.
module tb_l1_core_req_master;
  import l1_cache_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       lsu_valid;
  logic                       lsu_ready;
  logic [CORE_CMND_WIDTH-1:0] lsu_cmd;
  logic [AW-1:0]              lsu_addr;
  logic [DW-1:0]              lsu_wdata;
  logic                       lsu_rvalid;
  logic [DW-1:0]              lsu_rdata;
  logic                       lsu_err;
  logic                       req;
  logic [CORE_CMND_WIDTH-1:0] cmd;
  logic [AW-1:0]              addr;
  logic [DW-1:0]              wdata;
  logic                       req_ack;
  logic                       resp;
  logic [DW-1:0]              rdata;
  logic                       proto_err;

  always #5 clk = ~clk;

  l1_core_req_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_cmd(lsu_cmd),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .req(req), .cmd(cmd), .addr(addr), .wdata(wdata),
    .req_ack(req_ack), .resp(resp), .rdata(rdata), .proto_err(proto_err)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_dly;
    int          resp_dly;
    bit          spur;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Completion monitor: every lsu_rvalid must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && lsu_rvalid) begin
      if (sb_q.size() == 0) begin
        fail_now("unexpected_rvalid");
      end else begin
        e = sb_q.pop_front();
        check("lsu_rdata", lsu_rdata, e.rdata);
        check("lsu_err", {31'd0, lsu_err}, {31'd0, e.err});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sb();
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      fail_now("completion_timeout");
      sb_q.delete();
    end
    step();
  endtask

  task automatic do_txn(input vec_t v);
    int n = 0;
    exp_t e;
    while (!lsu_ready && n < 50) begin
      step();
      n++;
    end
    check("ready_before_txn", {31'd0, lsu_ready}, 32'd1);
    lsu_valid = 1'b1;
    lsu_cmd   = v.cmd;
    lsu_addr  = v.addr;
    lsu_wdata = v.wdata;
    e.rdata   = v.exp_rdata;
    e.err     = v.exp_err;
    sb_q.push_back(e);
    step();
    lsu_valid = 1'b0;
    lsu_addr  = $urandom;
    lsu_wdata = $urandom;
    if (v.cmd == 2'b11) begin
      @(negedge clk);
      check("rsvd_no_req", {31'd0, req}, 32'd0);
      step();
      check("rsvd_no_req_later", {31'd0, req}, 32'd0);
    end else begin
      for (int i = 0; i < v.ack_dly; i++) begin
        if (v.spur && i == 0) begin
          resp  = 1'b1;
          rdata = $urandom;
        end
        @(negedge clk);
        check("req_held", {31'd0, req}, 32'd1);
        check("addr_stable", addr, v.addr);
        check("cmd_stable", {30'd0, cmd}, {30'd0, v.cmd});
        check("wdata_stable", wdata, v.wdata);
        step();
        resp = 1'b0;
      end
      req_ack = 1'b1;
      if (v.resp_dly == 0) begin
        resp  = 1'b1;
        rdata = v.rdata;
      end
      @(negedge clk);
      check("req_at_ack", {31'd0, req}, 32'd1);
      check("addr_at_ack", addr, v.addr);
      step();
      req_ack = 1'b0;
      resp    = 1'b0;
      if (v.resp_dly > 0) begin
        for (int i = 0; i < v.resp_dly - 1; i++) begin
          @(negedge clk);
          check("wait_req_low", {31'd0, req}, 32'd0);
          check("wait_no_rvalid", {31'd0, lsu_rvalid}, 32'd0);
          step();
        end
        resp  = 1'b1;
        rdata = v.rdata;
        @(negedge clk);
        check("wait_req_low_resp", {31'd0, req}, 32'd0);
        step();
        resp = 1'b0;
      end
      check("ready_at_completion", {31'd0, lsu_ready}, 32'd1);
    end
    wait_sb();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    exp_t e;
    int   cnt;

    vecs[0] = '{CMD_RD,    32'h0000_0100, 32'h0,           2, 2, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{CMD_WR,    32'h0000_0204, 32'h1234_5678,   0, 0, 1'b0, 32'hAAAA_5555, 32'h0,         1'b0};
    vecs[2] = '{CMD_FLUSH, 32'h0000_03FC, 32'h0,           1, 1, 1'b1, 32'h1111_2222, 32'h0,         1'b0};
    vecs[3] = '{CMD_RD,    32'hFFFF_FFFC, 32'h0,           0, 1, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{CMD_RD,    32'h0000_0000, 32'h5A5A_5A5A,   0, 0, 1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0};
    vecs[5] = '{2'b11,     32'h0000_0700, 32'h0,           0, 0, 1'b0, 32'h0,         32'h0,         1'b1};

    rst = 1'b1; lsu_valid = 1'b0; lsu_cmd = 2'b00; lsu_addr = '0; lsu_wdata = '0;
    req_ack = 1'b0; resp = 1'b0; rdata = '0;
    repeat (3) step();
    @(negedge clk);
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_cmd", {30'd0, cmd}, 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_rvalid", {31'd0, lsu_rvalid}, 32'd0);
    check("rst_rdata", lsu_rdata, 32'd0);
    check("rst_err", {31'd0, lsu_err}, 32'd0);
    check("rst_proto", {31'd0, proto_err}, 32'd0);
    check("rst_ready", {31'd0, lsu_ready}, 32'd1);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) do_txn(vecs[i]);
    check("no_proto_after_table", {31'd0, proto_err}, 32'd0);

    // Minimum latency write, then a request accepted on the completion cycle.
    lsu_valid = 1'b1; lsu_cmd = CMD_WR; lsu_addr = 32'h40; lsu_wdata = 32'h1234_5678;
    e.rdata = 32'h0; e.err = 1'b0; sb_q.push_back(e);
    step();
    lsu_valid = 1'b0; req_ack = 1'b1; resp = 1'b1; rdata = 32'h5555_AAAA;
    @(negedge clk);
    check("wr_req", {31'd0, req}, 32'd1);
    check("wr_wdata", wdata, 32'h1234_5678);
    step();
    req_ack = 1'b0; resp = 1'b0;
    lsu_valid = 1'b1; lsu_cmd = CMD_RD; lsu_addr = 32'h80;
    e.rdata = 32'h0BAD_F00D; e.err = 1'b0; sb_q.push_back(e);
    @(negedge clk);
    check("wr_rvalid_lat2", {31'd0, lsu_rvalid}, 32'd1);
    check("wr_ready_with_rvalid", {31'd0, lsu_ready}, 32'd1);
    step();
    lsu_valid = 1'b0;
    @(negedge clk);
    check("b2b_req", {31'd0, req}, 32'd1);
    check("b2b_addr", addr, 32'h80);
    check("b2b_rvalid_pulse", {31'd0, lsu_rvalid}, 32'd0);
    step();
    req_ack = 1'b1; resp = 1'b1; rdata = 32'h0BAD_F00D;
    step();
    req_ack = 1'b0; resp = 1'b0;
    wait_sb();

    // Reset while waiting for the response; the late response must be ignored.
    lsu_valid = 1'b1; lsu_cmd = CMD_RD; lsu_addr = 32'h500;
    step();
    lsu_valid = 1'b0; req_ack = 1'b1;
    step();
    req_ack = 1'b0;
    @(negedge clk);
    check("mid_wait_req_low", {31'd0, req}, 32'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_req", {31'd0, req}, 32'd0);
      check("mid_rst_no_rvalid", {31'd0, lsu_rvalid}, 32'd0);
      step();
    end
    resp = 1'b1; rdata = 32'hFFFF_0000;
    step();
    resp = 1'b0;
    @(negedge clk);
    check("late_resp_no_proto", {31'd0, proto_err}, 32'd0);
    check("late_resp_no_rvalid", {31'd0, lsu_rvalid}, 32'd0);
    step();

    // Spurious response in IDLE is sticky until reset.
    resp = 1'b1;
    step();
    resp = 1'b0;
    @(negedge clk);
    check("proto_set", {31'd0, proto_err}, 32'd1);
    repeat (3) step();
    check("proto_sticky", {31'd0, proto_err}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("proto_cleared", {31'd0, proto_err}, 32'd0);
    step();

    // Never acknowledged request.
    lsu_valid = 1'b1; lsu_cmd = CMD_RD; lsu_addr = 32'h600;
`ifdef L1_REQ_TIMEOUT_EN
    e.rdata = 32'h0; e.err = 1'b1; sb_q.push_back(e);
`endif
    step();
    lsu_valid = 1'b0;
    cnt = 0;
`ifdef L1_REQ_TIMEOUT_EN
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!req) break;
      cnt++;
      step();
    end
    check("timeout_req_cycles", cnt, TO);
    wait_sb();
`else
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (req) cnt++;
      step();
    end
    check("no_timeout_req_held", cnt, 32'd1000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
